// File: rtl/bram_stream_reader_pkg.sv
// Shared types and helpers for the BRAM burst stream reader.
// The FSM state encoding and the pointer-width helper are used by the top and its FIFO.
package bram_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Bits needed to index v entries (v >= 2).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/bram_stream_reader_sync_fifo.sv
// Small synchronous FIFO holding captured RAM words plus their end-of-burst flag.
// The head word is read straight from storage flops, so dout_o/valid_o have no input paths.
module sync_fifo
    import bram_stream_reader_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       din_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       dout_o,
    output logic                   valid_o,
    output logic [clog2(DEPTH):0]  count_o
);
    localparam int PW = clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW:0] FULL = CW'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [PW-1:0]               wr_ptr_q;
    logic [PW-1:0]               rd_ptr_q;
    logic [PW:0]                 count_q;
    logic                        do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign dout_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                // The issue logic upstream sizes reads so a push never lands on a full buffer.
                assert (count_q != FULL || do_pop);
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/bram_stream_reader.sv
// Burst read initiator for a 1-cycle-latency single-port BRAM: issues sequential reads,
// captures the returned words into a small buffer and streams them out over valid/ready.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_di,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);
    localparam int CW = clog2(BUF_DEPTH) + 1;
    localparam int LW = CW + 1;
    localparam logic [ADDR_WIDTH:0] LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic                  ram_en_q, ram_en_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic                  last_q, last_d;
    logic                  cap_q, cap_last_q;
    logic                  done_q, done_d;

    logic                  fifo_valid;
    logic                  fifo_last;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic [DATA_WIDTH:0]   fifo_dout;
    logic [CW-1:0]         fifo_count;
    logic                  pop;
    logic [LW-1:0]         load;
    logic                  fits;

    assign pop = fifo_valid & out_ready;

    // Worst-case buffer fill if one more read is issued now: words held (minus the one
    // leaving this cycle), the word arriving from the RAM, the read on the port, and the new one.
    assign load = LW'(fifo_count) + LW'(cap_q) + LW'(ram_en_q) + LW'(1) - LW'(pop);
    assign fits = (load <= LW'(BUF_DEPTH));

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        ram_en_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        last_d     = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = READ;
                        ram_en_d   = 1'b1;
                        ram_addr_d = cmd_addr;
                        rem_d      = cmd_len - 1'b1;
                        last_d     = (cmd_len == LEN_ONE);
                    end
                end
            end
            READ: begin
                if (rem_q != '0 && fits) begin
                    ram_en_d   = 1'b1;
                    ram_addr_d = ram_addr_q + 1'b1;
                    rem_d      = rem_q - 1'b1;
                    last_d     = (rem_q == LEN_ONE);
                end
                if (rem_d == '0) state_d = DRAIN;
            end
            DRAIN: begin
                if (pop && fifo_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            ram_en_q   <= 1'b0;
            ram_addr_q <= '0;
            last_q     <= 1'b0;
            cap_q      <= 1'b0;
            cap_last_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            ram_en_q   <= ram_en_d;
            ram_addr_q <= ram_addr_d;
            last_q     <= last_d;
            cap_q      <= ram_en_q;
            cap_last_q <= last_q;
            done_q     <= done_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cap_q),
        .din_i   ({cap_last_q, ram_dout}),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    assign fifo_last = fifo_dout[DATA_WIDTH];
    assign fifo_data = fifo_dout[DATA_WIDTH-1:0];

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign ram_en    = ram_en_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = 1'b0;
    assign ram_di    = '0;
    assign out_valid = fifo_valid;
    assign out_data  = fifo_data;
    assign out_last  = fifo_valid & fifo_last;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: preloaded RAM model, queue-based burst model checked every cycle,
// plus literal expectations for latency, wrap, zero-length, reset and full-RAM bursts.
module tb_bram_stream_reader;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int BD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW:0]   cmd_len = '0;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di;
    logic [DW-1:0] ram_dout = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_last, busy, done;

    bram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUF_DEPTH(BD)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_di(ram_di), .ram_dout(ram_dout), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [256];
    initial for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'hA5;
    always @(posedge clk) if (ram_en) ram_dout <= ram[ram_addr];

    int vec_cnt = 0;
    int miss_cnt = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct { logic [DW-1:0] data; logic last; } beat_t;
    typedef struct { logic [DW-1:0] data; logic last; int c; } obs_t;

    beat_t exp_q[$];
    int    addr_q[$];
    bit    mbusy = 0;
    bit    done_pend = 0;
    int    issued = 0;
    int    popped = 0;
    int    acc_cyc = 0;
    obs_t  out_log[$];
    int    en_log[$];
    int    done_log[$];

    // Reference model: an accepted burst becomes a list of addresses to read and words to
    // emit; everything the DUT shows is compared against the heads of those lists.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            addr_q.delete();
            mbusy = 0;
            done_pend = 0;
            issued = 0;
            popped = 0;
        end else begin
            chk("ram_we", int'(ram_we), 0);
            chk("cmd_ready", int'(cmd_ready), int'(!mbusy));
            chk("busy", int'(busy), int'(mbusy));
            chk("done", int'(done), int'(done_pend));
            if (done) done_log.push_back(cyc);
            done_pend = 0;
            if (ram_en) begin
                en_log.push_back(cyc);
                issued++;
                if (addr_q.size() == 0) begin
                    vec_cnt++; miss_cnt++;
                    $display("FAIL spurious_read: got addr %0h expected no read", ram_addr);
                end else chk("ram_addr", int'(ram_addr), addr_q.pop_front());
            end
            vec_cnt++;
            if (issued - popped > BD) begin
                miss_cnt++;
                $display("FAIL issue_bound: outstanding %0d exceeds %0d", issued - popped, BD);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    vec_cnt++; miss_cnt++;
                    $display("FAIL spurious_out: got data %0h expected no word", out_data);
                end else begin
                    chk("out_data", int'(out_data), int'(exp_q[0].data));
                    chk("out_last", int'(out_last), int'(exp_q[0].last));
                    if (out_ready) begin
                        out_log.push_back('{out_data, out_last, cyc});
                        if (exp_q[0].last) begin
                            mbusy = 0;
                            done_pend = 1;
                        end
                        void'(exp_q.pop_front());
                        popped++;
                    end
                end
            end
            if (cmd_valid && cmd_ready) begin
                acc_cyc = cyc;
                if (cmd_len == '0) done_pend = 1;
                else begin
                    int n;
                    n = int'(cmd_len);
                    mbusy = 1;
                    for (int i = 0; i < n; i++) begin
                        int a;
                        a = (int'(cmd_addr) + i) % 256;
                        addr_q.push_back(a);
                        exp_q.push_back('{8'(a) ^ 8'hA5, (i == n - 1)});
                    end
                end
            end
        end
    end

    task automatic clear_logs();
        out_log.delete();
        en_log.delete();
        done_log.delete();
    endtask

    task automatic send_cmd(input logic [AW-1:0] a, input logic [AW:0] l);
        bit ok;
        int n;
        ok = 0;
        n = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (cmd_ready) ok = 1;
            n++;
        end
        if (!ok) begin
            vec_cnt++; miss_cnt++;
            $display("FAIL cmd_accept_timeout: got cmd_ready=0 expected 1 within 200 cycles");
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // mode 0: ready held high, 1: ready toggles each cycle, 2: random ready
    task automatic run_wait(input int mode, input int bound);
        bit fin;
        int n;
        fin = 0;
        n = 0;
        while (!fin && n < bound) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) fin = 1;
            else begin
                @(posedge clk); #1;
                case (mode)
                    1:       out_ready = ~out_ready;
                    2:       out_ready = ($urandom % 3) != 0;
                    default: out_ready = 1'b1;
                endcase
            end
            n++;
        end
        if (!fin) begin
            vec_cnt++; miss_cnt++;
            $display("FAIL burst_timeout: got busy after %0d cycles expected idle", bound);
        end
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
        chk({tag, "_ram_en"}, int'(ram_en), 0);
        chk({tag, "_ram_addr"}, int'(ram_addr), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_last"}, int'(out_last), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;

        // burst at 0x10, four words, full throughput
        clear_logs();
        send_cmd(8'h10, 9'd4);
        run_wait(0, 100);
        chk("t1_words", out_log.size(), 4);
        if (out_log.size() == 4) begin
            chk("t1_d0", int'(out_log[0].data), 'hB5);
            chk("t1_d1", int'(out_log[1].data), 'hB4);
            chk("t1_d2", int'(out_log[2].data), 'hB7);
            chk("t1_d3", int'(out_log[3].data), 'hB6);
            chk("t1_last2", int'(out_log[2].last), 0);
            chk("t1_last3", int'(out_log[3].last), 1);
            chk("t1_first_out_cyc", out_log[0].c, acc_cyc + 3);
            chk("t1_last_out_cyc", out_log[3].c, acc_cyc + 6);
        end
        chk("t1_reads", en_log.size(), 4);
        if (en_log.size() == 4) begin
            chk("t1_first_en_cyc", en_log[0], acc_cyc + 1);
            chk("t1_last_en_cyc", en_log[3], acc_cyc + 4);
        end
        chk("t1_done_cyc", done_log.size() > 0 ? done_log[0] : -1, acc_cyc + 7);

        // zero-length burst
        clear_logs();
        send_cmd(8'h33, 9'd0);
        run_wait(0, 20);
        chk("t4_reads", en_log.size(), 0);
        chk("t4_words", out_log.size(), 0);
        chk("t4_done_cyc", done_log.size() > 0 ? done_log[0] : -1, acc_cyc + 1);

        // back-pressure: ready toggles every cycle
        clear_logs();
        out_ready = 1'b0;
        send_cmd(8'h80, 9'd8);
        run_wait(1, 200);
        chk("t3_words", out_log.size(), 8);
        if (out_log.size() == 8) chk("t3_d7", int'(out_log[7].data), 'h80 ^ 'hA5 ^ 7);

        // stray commands while busy, then reset in the middle of the burst
        send_cmd(8'h40, 9'd20);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b1; cmd_addr = 8'($urandom); cmd_len = 9'd3;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // wrap across the top of the address space, right after reset
        clear_logs();
        send_cmd(8'hFE, 9'd4);
        run_wait(0, 100);
        chk("t2_words", out_log.size(), 4);
        if (out_log.size() == 4) begin
            chk("t2_d0", int'(out_log[0].data), 'h5B);
            chk("t2_d1", int'(out_log[1].data), 'h5A);
            chk("t2_d2", int'(out_log[2].data), 'hA5);
            chk("t2_d3", int'(out_log[3].data), 'hA4);
        end

        // whole RAM in one burst
        clear_logs();
        send_cmd(8'h00, 9'd256);
        run_wait(0, 600);
        chk("t6_words", out_log.size(), 256);
        if (out_log.size() == 256) begin
            chk("t6_span", out_log[255].c - out_log[0].c, 255);
            chk("t6_last", int'(out_log[255].last), 1);
            chk("t6_last_prev", int'(out_log[254].last), 0);
        end

        // random bursts with random back-pressure
        for (int k = 0; k < 25; k++) begin
            logic [AW:0] l;
            l = ($urandom % 8 == 0) ? 9'd0 : 9'($urandom_range(1, 24));
            send_cmd(8'($urandom), l);
            run_wait(2, 800);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish within 2ms");
        $fatal(1, "timeout");
    end

endmodule
